// File: rtl/t2mi_packer_ctrl.sv
// t2mi_packer_ctrl: run/stop sequencer and token-bucket rate pacer for the
// TS->T2-MI packet builder. It gates the builder's clock enable by two things:
// downstream FIFO fill level (with hysteresis) and a fractional byte rate.
// It only stops on a packet boundary, so the builder always halts at a header.
module t2mi_packer_ctrl #(
  parameter int FIFO_AW    = 10,
  parameter int HI_WM      = 1000,
  parameter int LO_WM      = 768,
  parameter int BUCKET_MAX = 512
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic [15:0]        RATE_INC,
  input  logic [3:0]         PKT_STATE,
  input  logic               PKT_ENA_OUT,
  input  logic [FIFO_AW-1:0] FIFO_USEDW,
  input  logic               FIFO_FULL,
  output logic               ENA_TS2T2MI,
  output logic               RUNNING,
  output logic               PKT_DONE,
  output logic [15:0]        PKT_CNT,
  output logic               OVF
);

  localparam int TOK_W = $clog2(BUCKET_MAX + 1);

  localparam logic [FIFO_AW-1:0] HI_LVL  = FIFO_AW'(HI_WM);
  localparam logic [FIFO_AW-1:0] LO_LVL  = FIFO_AW'(LO_WM);
  localparam logic [TOK_W:0]     TOK_MAX = (TOK_W + 1)'(BUCKET_MAX);

  // Builder state codes that bracket a packet.
  localparam logic [3:0] PS_HDR = 4'd0;
  localparam logic [3:0] PS_CRC = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [TOK_W-1:0] tokens;
  logic [15:0]      frac_acc;
  logic             throttle;
  logic [3:0]       pkt_state_d;

  logic             byte_w;
  logic             done_det;
  logic [16:0]      frac_sum;
  logic             carry;
  logic [TOK_W:0]   tok_sum;
  logic [TOK_W-1:0] tok_next;

  // Enable is decoded from registers only, so there is no input-to-output path.
  assign ENA_TS2T2MI = (state != ST_IDLE) & ~throttle & (tokens != '0);

  assign byte_w   = ENA_TS2T2MI & PKT_ENA_OUT;
  // A packet has finished when the builder steps from CRC-32 back to header.
  assign done_det = (pkt_state_d == PS_CRC) & (PKT_STATE == PS_HDR);

  // Fractional accumulator: the carry out of the 16-bit add is one whole token.
  assign frac_sum = {1'b0, frac_acc} + {1'b0, RATE_INC};
  assign carry    = frac_sum[16];

  // Bucket update; a byte always has a token behind it, so no underflow.
  always_comb begin
    tok_sum  = {1'b0, tokens} + {{TOK_W{1'b0}}, carry} - {{TOK_W{1'b0}}, byte_w};
    tok_next = tokens;
    if (tok_sum > TOK_MAX) tok_next = TOK_MAX[TOK_W-1:0];
    else                   tok_next = tok_sum[TOK_W-1:0];
  end

  // Token pacer runs in every state so the bucket fills while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frac_acc <= '0;
      tokens   <= '0;
    end else begin
      frac_acc <= frac_sum[15:0];
      tokens   <= tok_next;
    end
  end

  // FIFO-level throttle with hysteresis between the two watermarks.
  always_ff @(posedge CLK) begin
    if (RST)                      throttle <= 1'b0;
    else if (FIFO_USEDW >= HI_LVL) throttle <= 1'b1;
    else if (FIFO_USEDW <= LO_LVL) throttle <= 1'b0;
  end

  // Run/stop sequencer; RUNNING is registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      RUNNING <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state   <= ST_RUN;
            RUNNING <= 1'b1;
          end
        end
        ST_RUN: begin
          if (STOP) begin
            // Stopping exactly on a boundary skips the drain phase.
            if (done_det) begin
              state   <= ST_IDLE;
              RUNNING <= 1'b0;
            end else begin
              state   <= ST_DRAIN;
              RUNNING <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (done_det) begin
            state   <= ST_IDLE;
            RUNNING <= 1'b0;
          end else if (START) begin
            // A fresh start cancels the pending stop.
            state   <= ST_RUN;
            RUNNING <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          RUNNING <= 1'b0;
        end
      endcase
    end
  end

  // Packet boundary tracking: delayed builder state, done pulse and counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pkt_state_d <= '0;
      PKT_DONE    <= 1'b0;
      PKT_CNT     <= '0;
    end else begin
      pkt_state_d <= PKT_STATE;
      PKT_DONE    <= done_det;
      PKT_CNT     <= PKT_CNT + {15'd0, done_det};
    end
  end

  // Sticky overflow flag; only a restart from idle clears it.
  always_ff @(posedge CLK) begin
    if (RST)                              OVF <= 1'b0;
    else if (byte_w & FIFO_FULL)          OVF <= 1'b1;
    else if ((state == ST_IDLE) & START)  OVF <= 1'b0;
  end

endmodule

// File: tb/tb_t2mi_packer_ctrl.sv
// tb_t2mi_packer_ctrl: directed and randomized stimulus for the packer
// controller. A behavioural model predicts the outputs after each clock and
// queues them; an independent monitor pops and compares after every edge.
module tb_t2mi_packer_ctrl;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] rate = 16'd0;
  logic [3:0]  pst = 4'd0;
  logic        pena = 1'b0;
  logic [9:0]  usedw = 10'd0;
  logic        full = 1'b0;

  logic        ena, running, pkt_done, ovf;
  logic [15:0] pkt_cnt;

  t2mi_packer_ctrl dut (
    .CLK(CLK), .RST(rst), .START(start), .STOP(stop), .RATE_INC(rate),
    .PKT_STATE(pst), .PKT_ENA_OUT(pena), .FIFO_USEDW(usedw), .FIFO_FULL(full),
    .ENA_TS2T2MI(ena), .RUNNING(running), .PKT_DONE(pkt_done),
    .PKT_CNT(pkt_cnt), .OVF(ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit ena;
    bit run;
    bit done;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: mode 0 = stopped, 1 = running, 2 = finishing current packet.
  int m_mode = 0, m_tok = 0, m_frac = 0, m_thr = 0, m_psd = 0;
  int m_done = 0, m_cnt = 0, m_ovf = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the next prediction.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ena",      int'(ena),      int'(mon_e.ena));
      chk("running",  int'(running),  int'(mon_e.run));
      chk("pkt_done", int'(pkt_done), int'(mon_e.done));
      chk("pkt_cnt",  int'(pkt_cnt),  mon_e.cnt);
      chk("ovf",      int'(ovf),      int'(mon_e.ovf));
    end
  end

  // Apply the current inputs for one clock, advance the model, queue the result.
  task automatic step();
    exp_t e;
    int byt, done, carry;
    byt = (m_mode != 0 && m_thr == 0 && m_tok > 0 && pena) ? 1 : 0;
    if (rst) begin
      m_mode = 0; m_tok = 0; m_frac = 0; m_thr = 0; m_psd = 0;
      m_done = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      done   = (m_psd == 7 && pst == 0) ? 1 : 0;
      m_frac = m_frac + int'(rate);
      carry  = (m_frac >= 65536) ? 1 : 0;
      if (carry != 0) m_frac = m_frac - 65536;
      m_tok = m_tok + carry - byt;
      if (m_tok > 512) m_tok = 512;
      if (usedw >= 10'd1000)     m_thr = 1;
      else if (usedw <= 10'd768) m_thr = 0;
      if (byt != 0 && full)           m_ovf = 1;
      else if (m_mode == 0 && start)  m_ovf = 0;
      case (m_mode)
        0: if (start) m_mode = 1;
        1: if (stop) m_mode = (done != 0) ? 0 : 2;
        default: if (done != 0) m_mode = 0; else if (start) m_mode = 1;
      endcase
      m_done = done;
      m_cnt  = (m_cnt + done) % 65536;
      m_psd  = int'(pst);
    end
    e.ena  = (m_mode != 0 && m_thr == 0 && m_tok > 0);
    e.run  = (m_mode != 0);
    e.done = (m_done != 0);
    e.cnt  = m_cnt;
    e.ovf  = (m_ovf != 0);
    exp_q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    @(negedge CLK);
    // Reset state
    rst = 1'b1; steps(2);
    rst = 1'b0; steps(2);

    // Half rate, unthrottled: enable two cycles after start, then 50% duty
    rate = 16'h8000; pena = 1'b1; usedw = 10'd0;
    start = 1'b1; steps(40);

    // Full rate with FIFO ramp across both watermarks
    rate = 16'hFFFF;
    for (int u = 0; u <= 1000; u += 100) begin usedw = 10'(u); step(); end
    usedw = 10'd1000; steps(3);
    usedw = 10'd900;  steps(3);
    usedw = 10'd800;  steps(2);
    usedw = 10'd768;  steps(3);
    usedw = 10'd0;    steps(2);

    // Stop mid-packet -> drain, then boundary ends it
    pst = 4'd3; steps(2);
    stop = 1'b1; steps(3);
    pst = 4'd7; steps(2);
    pst = 4'd0; steps(4);

    // Stop on the exact boundary cycle -> straight to idle
    start = 1'b1; step();
    pst = 4'd5; steps(2);
    pst = 4'd7; steps(2);
    pst = 4'd0; stop = 1'b1; steps(3);

    // Start during drain cancels the stop
    start = 1'b1; steps(2);
    pst = 4'd2; stop = 1'b1; steps(2);
    start = 1'b1; steps(2);
    pst = 4'd7; step();
    pst = 4'd0; steps(3);
    pst = 4'd4; stop = 1'b1; step();
    pst = 4'd7; step();
    pst = 4'd0; steps(2);

    // Long idle fills the bucket to saturation, then a burst drains it
    pena = 1'b0; steps(2000);
    pena = 1'b1; start = 1'b1; steps(20);
    rate = 16'h1000; steps(560);

    // Overflow is sticky through stop, cleared by start from idle
    full = 1'b1; steps(4);
    full = 1'b0; pst = 4'd3; stop = 1'b1; steps(2);
    pst = 4'd7; step();
    pst = 4'd0; steps(3);
    start = 1'b1; steps(3);

    // Reset mid-run clears everything
    rate = 16'hC000; full = 1'b1; steps(4);
    rst = 1'b1; step();
    rst = 1'b0; full = 1'b0; steps(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 16'h0000;
          1: rate = 16'hFFFF;
          default: rate = 16'($urandom);
        endcase
      end
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      pena  = ($urandom_range(0, 3) != 0);
      full  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0: usedw = 10'($urandom_range(0, 1023));
        1: usedw = 10'($urandom_range(760, 1010));
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) pst = (pst == 4'd7) ? 4'd0 : pst + 4'd1;
      step();
    end
    rst = 1'b0;

    // Let the monitor consume all predictions, within a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
